// File: rtl/ib_vnu3_v2c_tx_pkg.sv
// Shared types for the V2C transmit block: FSM encoding and default message width.
package ib_vnu3_v2c_tx_pkg;

  localparam int QUAN_SIZE_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER0 = 2'd1,
    ITERN = 2'd2,
    DRAIN = 2'd3
  } v2c_state_e;

endpackage

// File: rtl/ib_vnu3_v2c_tx_fifo.sv
// Two-entry FIFO with a registered head: 1-cycle latency into an empty FIFO, push ignored when full.
// The head register keeps its last value while empty so the outputs stay stable.
module ib_v2c_skid_fifo #(
  parameter int WIDTH = 11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push_vld,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop_rdy,
  output logic             o_head_vld,
  output logic [WIDTH-1:0] o_head_dat,
  output logic [1:0]       o_cnt
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_head_vld = (r_cnt != 2'd0);
  assign o_head_dat = r_head;
  assign o_cnt      = r_cnt;
  assign w_push     = i_push_vld && (r_cnt != 2'd2);
  assign w_pop      = o_head_vld && i_pop_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= i_push_dat;
          else               r_tail <= i_push_dat;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd2) r_head <= r_tail;
          r_cnt <= r_cnt - 2'd1;
        end
        // push implies count < 2, so with a pop the count is exactly 1
        2'b11:   r_head <= i_push_dat;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ib_vnu3_v2c_tx.sv
// V2C transmit for a degree-3 VNU: source mux, layer tagging, iteration tracking, 2-deep output FIFO.
// Beats reach the outputs 1 cycle after acceptance; in_ready depends only on state and FIFO count.
module ib_vnu3_v2c_tx
  import ib_vnu3_v2c_tx_pkg::*;
#(
  parameter int QUAN_SIZE   = QUAN_SIZE_DEF,
  parameter int LAYER_NUM   = 4,
  parameter int LAYER_WIDTH = 2,
  parameter int MAX_ITER    = 10,
  parameter int ITER_WIDTH  = 4
) (
  input  logic                   read_clk,
  input  logic                   rstn,
  input  logic                   dec_start,
  input  logic [QUAN_SIZE-1:0]   M0,
  input  logic [QUAN_SIZE-1:0]   M1,
  input  logic [QUAN_SIZE-1:0]   M2,
  input  logic [QUAN_SIZE-1:0]   ch_llr,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [QUAN_SIZE-1:0]   v2c0_out,
  output logic [QUAN_SIZE-1:0]   v2c1_out,
  output logic [QUAN_SIZE-1:0]   v2c2_out,
  output logic [LAYER_WIDTH-1:0] v2c_layer,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   v2c_src,
  output logic [ITER_WIDTH-1:0]  iter_cnt,
  output logic                   dec_done
);

  localparam int DW = 3*QUAN_SIZE + LAYER_WIDTH;
  localparam logic [LAYER_WIDTH-1:0] LAST_LAYER = LAYER_WIDTH'(LAYER_NUM - 1);
  localparam logic [ITER_WIDTH-1:0]  LAST_ITER  = ITER_WIDTH'(MAX_ITER - 1);

  v2c_state_e             r_state;
  v2c_state_e             w_state_nxt;
  logic [LAYER_WIDTH-1:0] r_layer;
  logic [LAYER_WIDTH-1:0] w_layer_nxt;
  logic [ITER_WIDTH-1:0]  r_iter;
  logic [ITER_WIDTH-1:0]  w_iter_nxt;
  logic [1:0]             w_fifo_cnt;
  logic                   w_acc;
  logic [DW-1:0]          w_push_dat;
  logic [DW-1:0]          w_head_dat;

  assign v2c_src  = (r_state == ITER0);
  assign in_ready = ((r_state == ITER0) || (r_state == ITERN)) && (w_fifo_cnt != 2'd2);
  assign w_acc    = in_valid && in_ready;
  assign iter_cnt = r_iter;

  // first iteration has no VNU history yet, so the channel LLR goes out on every edge
  assign w_push_dat = v2c_src ? {r_layer, ch_llr, ch_llr, ch_llr}
                              : {r_layer, M0, M1, M2};
  assign {v2c_layer, v2c0_out, v2c1_out, v2c2_out} = w_head_dat;

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_layer <= '0;
      r_iter  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_layer <= w_layer_nxt;
      r_iter  <= w_iter_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_layer_nxt = r_layer;
    w_iter_nxt  = r_iter;
    dec_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (dec_start) begin
          w_state_nxt = ITER0;
          w_layer_nxt = '0;
          w_iter_nxt  = '0;
        end
      end
      ITER0, ITERN: begin
        if (w_acc) begin
          if (r_layer == LAST_LAYER) begin
            w_layer_nxt = '0;
            // the final iteration count is held for observation until the next codeword
            if (r_iter == LAST_ITER) begin
              w_state_nxt = DRAIN;
            end else begin
              w_iter_nxt  = r_iter + 1'b1;
              w_state_nxt = ITERN;
            end
          end else begin
            w_layer_nxt = r_layer + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (w_fifo_cnt == 2'd0) begin
          w_state_nxt = IDLE;
          dec_done    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  ib_v2c_skid_fifo #(
    .WIDTH(DW)
  ) u_fifo (
    .i_clk      (read_clk),
    .i_rst_n    (rstn),
    .i_push_vld (w_acc),
    .i_push_dat (w_push_dat),
    .i_pop_rdy  (out_ready),
    .o_head_vld (out_valid),
    .o_head_dat (w_head_dat),
    .o_cnt      (w_fifo_cnt)
  );

endmodule

// File: doc/ib_vnu3_v2c_tx.md
Name: ib_vnu3_v2c_tx

Overview:
- Transmit side of the variable-to-check (V2C) path for one degree-3 variable node unit in the 3-bit IB layered decoder.
- Selects the source of the outgoing messages: channel LLR in the first iteration, VNU outputs M0..M2 afterwards.
- Tags each beat with its layer index and buffers it in a 2-entry FIFO towards the check-node side, using a valid/ready handshake.
- Tracks layer and iteration progress per codeword and signals decoding completion.

Parameters:
- QUAN_SIZE, 3, message width in bits.
- LAYER_NUM, 4, layers per iteration (must be >= 1).
- LAYER_WIDTH, 2, width of layer counter, ceil(log2(LAYER_NUM)) with minimum 1.
- MAX_ITER, 10, iterations per codeword (must be >= 1).
- ITER_WIDTH, 4, width of iteration counter, able to hold MAX_ITER-1.

Ports:
- read_clk  in  1  sole clock, rising edge.
- rstn  in  1  reset; asynchronous assert, active-low.
- dec_start  in  1  one-cycle pulse starting a new codeword; ignored unless state is IDLE.
- M0, M1, M2  in  QUAN_SIZE each  VNU outgoing V2C messages.
- ch_llr  in  QUAN_SIZE  channel LLR of this variable node.
- in_valid  in  1  M*/ch_llr valid.
- in_ready  out  1  block accepts a beat.
- v2c0_out, v2c1_out, v2c2_out  out  QUAN_SIZE each  outgoing messages (FIFO head).
- v2c_layer  out  LAYER_WIDTH  layer index of the head beat.
- out_valid  out  1  head beat valid.
- out_ready  in  1  check-node side accepts the head beat.
- v2c_src  out  1  1 while in the first iteration (channel bypass), else 0.
- iter_cnt  out  ITER_WIDTH  current iteration index.
- dec_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; layer and iteration counters 0; FIFO empty.
  - Outputs during reset: all data outputs 0, in_ready=0, out_valid=0, v2c_src=0, iter_cnt=0, dec_done=0.
  - Reset asserted mid-codeword discards all FIFO contents immediately.
- FSM states: IDLE, ITER0, ITERN, DRAIN.
  - IDLE -> ITER0 on dec_start; counters cleared.
  - ITER0 -> ITERN on the accepted beat with layer=LAYER_NUM-1, when MAX_ITER>1.
  - ITER0 or ITERN -> DRAIN on the accepted beat with layer=LAYER_NUM-1 and iter=MAX_ITER-1.
  - DRAIN -> IDLE when the FIFO is empty. dec_done=1 for exactly that transition cycle.
- Outputs by state:
  - v2c_src=1 only in ITER0.
  - in_ready=1 only in ITER0/ITERN with FIFO count<2. It is derived from registered state and count only; there is no combinational path from out_ready.
- Accept and push: a beat is accepted when in_valid && in_ready.
  - Pushed data is ch_llr replicated into all three slots if v2c_src=1; otherwise {M0, M1, M2}.
  - The current layer counter value is pushed alongside the data.
- Counters:
  - Layer counter increments per accepted beat, wrapping LAYER_NUM-1 -> 0.
  - On wrap, the iteration counter increments.
  - iter_cnt holds its final value in DRAIN and clears on the next dec_start.
- FIFO: 2 entries. out_valid = (count != 0). Pop on out_valid && out_ready.
  - Latency: a beat accepted at edge N appears at the outputs after edge N when the FIFO is empty, i.e. 1 cycle.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Full: in_ready=0, no push.
  - Empty: out_valid=0; data outputs hold their last value.
- dec_start outside IDLE has no effect. in_valid in IDLE/DRAIN is not accepted.

Decomposition:
- Shared package/define header holds the FSM state encodings (IDLE=2'd0, ITER0=2'd1, ITERN=2'd2, DRAIN=2'd3) and the QUAN_SIZE default.
- Sub-module ib_v2c_skid_fifo: 2-entry FIFO, width 3*QUAN_SIZE+LAYER_WIDTH, async active-low reset. Instantiated once.
- FSM, counters and source mux stay in the top level.

Test Plan:
- Reset check: assert rstn low mid-operation with 2 beats buffered -> out_valid=0, in_ready=0, iter_cnt=0 immediately (asynchronous). After release, state is IDLE and dec_start is required.
- First-iteration bypass: LAYER_NUM=4, MAX_ITER=2, out_ready=1, dec_start, ch_llr=3'b101, M*=3'b010 for 4 beats -> outputs all 3'b101, v2c_layer 0,1,2,3, v2c_src=1. The next 4 beats output 3'b010 with v2c_src=0 and iter_cnt=1.
- Backpressure: out_ready=0, in_valid=1 -> exactly 2 beats accepted, then in_ready=0. Raising out_ready drains them in order, with 1 beat per cycle thereafter.
- Simultaneous push and pop with count=1: data ordering is preserved and count stays at 1.
- Completion: MAX_ITER=2, LAYER_NUM=4 -> after the 8th accepted beat in_ready=0; dec_done pulses once, one cycle after the last pop; state returns to IDLE.
- Spurious inputs: dec_start pulsed during ITERN and in_valid=1 in IDLE -> no state change, no push, counters unchanged.
